// File: rtl/iommu_msi_ig.sv
// IOMMU MSI generator: turns interrupt-pending edges into single-beat 32-bit AXI4 MSI writes.
// Latency: a pending edge yields AW/W valid 2 cycles later; 3 cycles minimum per MSI, one write outstanding.
// Backpressure: AW/W held stable until their own ready; a masked or blocked vector stays pending, never dropped.
//
// Ports:
//   clk_i, rst_ni       clock (rising edge), asynchronous active-low reset
//   msi_en_i            1 = MSI mode; 0 = edges are dropped and no new MSI is started
//   intr_pend_i         level pending bits per source (0=cip, 1=fip, 2=pmip, 3=pip)
//   intr_vec_i          4-bit vector index per source (low log2(N_INT_VEC) bits used)
//   msi_addr_i/_data_i  MSI table address (bits [1:0] ignored) and data per vector
//   msi_mask_i          per-vector mask; masked vectors are held pending
//   mem_req_o           AXI master request, packed MSB->LSB:
//                         aw_valid, aw_id, aw_addr, aw_len[7:0], aw_size[2:0], aw_burst[1:0], aw_lock,
//                         aw_cache[3:0], aw_prot[2:0], aw_qos[3:0], aw_user, w_valid, w_data, w_strb,
//                         w_last, b_ready, ar_valid, r_ready
//   mem_resp_i          AXI master response, packed MSB->LSB:
//                         aw_ready, w_ready, b_valid, b_id, b_resp[1:0], ar_ready, r_valid
//   msi_err_o           1-cycle pulse when a write completes with a non-OKAY response
//   msi_err_vec_o       vector index of that failed write
//   msi_err_cnt_o       saturating count of failed MSIs     (only live with IOMMU_MSI_ERR_LOG_EN, else 0)
//   msi_err_addr_o      awaddr of the latest failed MSI     (only live with IOMMU_MSI_ERR_LOG_EN, else 0)
//
// Build option: define IOMMU_MSI_ERR_LOG_EN to enable the error counter and error address log.

module iommu_msi_ig #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned N_INT_SRC  = 4,
    parameter int unsigned N_INT_VEC  = 16,
    parameter int unsigned MSI_ID     = 0,
    localparam int unsigned REQ_W = ID_WIDTH + ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH / 8 + 32,
    localparam int unsigned RSP_W = ID_WIDTH + 7
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            msi_en_i,
    input  logic [N_INT_SRC-1:0]            intr_pend_i,
    input  logic [N_INT_SRC*4-1:0]          intr_vec_i,
    input  logic [N_INT_VEC*ADDR_WIDTH-1:0] msi_addr_i,
    input  logic [N_INT_VEC*32-1:0]         msi_data_i,
    input  logic [N_INT_VEC-1:0]            msi_mask_i,
    output logic [REQ_W-1:0]                mem_req_o,
    input  logic [RSP_W-1:0]                mem_resp_i,
    output logic                            msi_err_o,
    output logic [3:0]                      msi_err_vec_o,
    output logic [7:0]                      msi_err_cnt_o,
    output logic [ADDR_WIDTH-1:0]           msi_err_addr_o
);

    localparam int unsigned IDXW = $clog2(N_INT_VEC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT_B = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Response unpacking
    // ------------------------------------------------------------------
    logic                aw_ready;
    logic                w_ready;
    logic                b_valid;
    logic [1:0]          b_resp;
    logic [ID_WIDTH-1:0] unused_b_id;
    logic                unused_ar_ready;
    logic                unused_r_valid;

    assign {aw_ready, w_ready, b_valid, unused_b_id, b_resp, unused_ar_ready, unused_r_valid} = mem_resp_i;

    // Upper index bits and the low address bits are don't-care by design.
    logic unused_in;
    assign unused_in = ^{intr_vec_i, msi_addr_i};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q;
    logic                   aw_valid_q;
    logic                   w_valid_q;
    logic                   b_ready_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [31:0]            data_q;
    logic [IDXW-1:0]        idx_q;
    logic                   err_q;
    logic [3:0]             err_vec_q;
    logic [N_INT_SRC-1:0]   src_q;
    logic [N_INT_VEC-1:0]   vec_pend_q;
    logic [N_INT_VEC-1:0]   vec_pend_d;

    logic [N_INT_VEC-1:0]   vec_set;
    logic [N_INT_VEC-1:0]   vec_clr;
    logic                   b_fire;
    logic                   aw_left;
    logic                   w_left;
    logic                   sel_vld;
    logic [IDXW-1:0]        sel_idx;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [31:0]            sel_data;

    assign b_fire  = (state_q == ST_WAIT_B) && b_ready_q && b_valid;
    // A channel is still owed a handshake if it is valid and not accepted this cycle.
    assign aw_left = aw_valid_q && !aw_ready;
    assign w_left  = w_valid_q && !w_ready;

    // ------------------------------------------------------------------
    // Edge detection and pending-vector bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        vec_set = '0;
        for (int s = 0; s < N_INT_SRC; s++) begin
            // Edges seen while MSIs are disabled are consumed (src_q still follows) and lost.
            if (msi_en_i && intr_pend_i[s] && !src_q[s]) begin
                vec_set[intr_vec_i[s*4 +: IDXW]] = 1'b1;
            end
        end
    end

    always_comb begin
        vec_clr = '0;
        if (b_fire) begin
            vec_clr[idx_q] = 1'b1;
        end
        // Set after clear: a fresh edge on the vector just completed re-arms it.
        vec_pend_d = (vec_pend_q & ~vec_clr) | vec_set;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q      <= '0;
            vec_pend_q <= '0;
        end else begin
            src_q      <= intr_pend_i;
            vec_pend_q <= vec_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Lowest-index unmasked pending vector
    // ------------------------------------------------------------------
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int v = N_INT_VEC - 1; v >= 0; v--) begin
            if (vec_pend_q[v] && !msi_mask_i[v]) begin
                sel_vld = 1'b1;
                sel_idx = IDXW'(v);
            end
        end
    end

    assign sel_addr = msi_addr_i[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = msi_data_i[sel_idx*32 +: 32];

    // ------------------------------------------------------------------
    // Write FSM; all AXI control outputs are registered
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            err_vec_q  <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (msi_en_i && sel_vld) begin
                        addr_q     <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
                        data_q     <= sel_data;
                        idx_q      <= sel_idx;
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // AW and W complete independently, in either order or together.
                    aw_valid_q <= aw_left;
                    w_valid_q  <= w_left;
                    if (!aw_left && !w_left) begin
                        b_ready_q <= 1'b1;
                        state_q   <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (b_fire) begin
                        b_ready_q <= 1'b0;
                        state_q   <= ST_IDLE;
                        // Failed MSIs are reported, never retried.
                        if (b_resp != 2'b00) begin
                            err_q     <= 1'b1;
                            err_vec_q <= 4'(idx_q);
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    aw_valid_q <= 1'b0;
                    w_valid_q  <= 1'b0;
                    b_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign msi_err_o     = err_q;
    assign msi_err_vec_o = err_vec_q;

    // ------------------------------------------------------------------
    // Write data lane placement: the 32-bit MSI is replicated across the
    // bus and the strobe picks the lane addressed by awaddr.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;

    generate
        if (DATA_WIDTH == 64) begin : g_dw64
            assign w_data = {data_q, data_q};
            assign w_strb = addr_q[2] ? 8'hF0 : 8'h0F;
        end else begin : g_dw32
            assign w_data = data_q;
            assign w_strb = 4'hF;
        end
    endgenerate

    assign mem_req_o = {
        aw_valid_q,
        ID_WIDTH'(MSI_ID),
        addr_q,
        8'd0,          // aw_len: single beat
        3'b010,        // aw_size: 4 bytes
        2'b01,         // aw_burst: INCR
        1'b0,          // aw_lock
        4'd0,          // aw_cache
        3'd0,          // aw_prot
        4'd0,          // aw_qos
        1'b0,          // aw_user
        w_valid_q,
        w_data,
        w_strb,
        1'b1,          // w_last
        b_ready_q,
        1'b0,          // ar_valid: read channels idle
        1'b1           // r_ready
    };

    // ------------------------------------------------------------------
    // Optional error log
    // ------------------------------------------------------------------
`ifdef IOMMU_MSI_ERR_LOG_EN
    logic [7:0]            err_cnt_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else if (b_fire && (b_resp != 2'b00)) begin
            if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            err_addr_q <= addr_q;
        end
    end

    assign msi_err_cnt_o  = err_cnt_q;
    assign msi_err_addr_o = err_addr_q;
`else
    assign msi_err_cnt_o  = '0;
    assign msi_err_addr_o = '0;
`endif

endmodule

// File: tb/tb_iommu_msi_ig.sv
// Directed bench for iommu_msi_ig: AXI slave model with configurable readies and B response.
// Latency: responds with B on the cycle after both AW and W have been accepted.
// Backpressure: aw_ready / w_ready / B release driven by the stimulus sequence.

module tb_iommu_msi_ig;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      msi_en;
    logic [3:0]                intr_pend;
    logic [15:0]               intr_vec;
    logic [16*AW-1:0]          msi_addr;
    logic [16*32-1:0]          msi_data;
    logic [15:0]               msi_mask;
    logic [IW+AW+DW+DW/8+31:0] mem_req;
    logic [IW+6:0]             mem_resp;
    logic                      msi_err;
    logic [3:0]                msi_err_vec;
    logic [7:0]                err_cnt;
    logic [AW-1:0]             err_addr;

    // request fields
    logic          aw_valid, aw_lock, aw_user, w_valid, w_last, b_ready, ar_valid, r_ready;
    logic [IW-1:0] aw_id;
    logic [AW-1:0] aw_addr;
    logic [7:0]    aw_len;
    logic [2:0]    aw_size, aw_prot;
    logic [1:0]    aw_burst;
    logic [3:0]    aw_cache, aw_qos;
    logic [DW-1:0] w_data;
    logic [7:0]    w_strb;

    assign {aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
            aw_qos, aw_user, w_valid, w_data, w_strb, w_last, b_ready, ar_valid, r_ready} = mem_req;

    // response drive
    logic       aw_ready, w_ready, b_valid;
    logic [1:0] b_resp;
    logic [1:0] bresp_cfg;
    logic       b_hold;

    assign mem_resp = {aw_ready, w_ready, b_valid, 4'd0, b_resp, 1'b0, 1'b0};

    iommu_msi_ig dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .msi_en_i       (msi_en),
        .intr_pend_i    (intr_pend),
        .intr_vec_i     (intr_vec),
        .msi_addr_i     (msi_addr),
        .msi_data_i     (msi_data),
        .msi_mask_i     (msi_mask),
        .mem_req_o      (mem_req),
        .mem_resp_i     (mem_resp),
        .msi_err_o      (msi_err),
        .msi_err_vec_o  (msi_err_vec),
        .msi_err_cnt_o  (err_cnt),
        .msi_err_addr_o (err_addr)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor (samples pre-edge values at the rising edge)
    // ------------------------------------------------------------------
    int            cyc = 0;
    int            aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int            aw_cyc = 0, w_cyc = 0;
    int            err_pulses = 0, stable_viol = 0, field_bad = 0, rd_bad = 0;
    logic [3:0]    err_vec_seen = '0;
    logic          aw_stall = 1'b0;
    logic [AW-1:0] prev_awaddr = '0;
    logic [AW-1:0] addr_log[$];
    logic [2:0]    size_log[$];
    logic [DW-1:0] wdata_log[$];
    logic [7:0]    wstrb_log[$];

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (aw_valid && aw_stall && (aw_addr !== prev_awaddr)) stable_viol++;
            aw_stall    = aw_valid && !aw_ready;
            prev_awaddr = aw_addr;
            if (aw_valid && aw_ready) begin
                aw_cnt++;
                aw_cyc = cyc;
                addr_log.push_back(aw_addr);
                size_log.push_back(aw_size);
                if (aw_len != 8'd0 || aw_burst != 2'b01 || aw_id != 4'd0 || aw_lock || aw_user ||
                    aw_cache != 4'd0 || aw_prot != 3'd0 || aw_qos != 4'd0) field_bad++;
            end
            if (w_valid && w_ready) begin
                w_cnt++;
                w_cyc = cyc;
                wdata_log.push_back(w_data);
                wstrb_log.push_back(w_strb);
                if (!w_last) field_bad++;
            end
            if (b_valid && b_ready) b_cnt++;
            if (msi_err) begin
                err_pulses++;
                err_vec_seen = msi_err_vec;
            end
            if (ar_valid || !r_ready) rd_bad++;
        end else begin
            aw_stall = 1'b0;
        end
    end

    // B channel: one response per accepted AW+W pair
    always @(negedge clk) begin
        b_valid = !b_hold && (aw_cnt > b_cnt) && (w_cnt > b_cnt);
        b_resp  = bresp_cfg;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_b(input int target, input string tag);
        int k = 0;
        while (b_cnt < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(b_cnt), 64'(target));
    endtask

    task automatic set_vec(input int v, input logic [63:0] a, input logic [31:0] d);
        msi_addr[v*AW +: AW] = a;
        msi_data[v*32 +: 32] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int c0;
        int k;
        rst_n     = 1'b0;
        msi_en    = 1'b1;
        intr_pend = '0;
        msi_addr  = '0;
        msi_data  = '0;
        msi_mask  = '0;
        aw_ready  = 1'b1;
        w_ready   = 1'b1;
        b_valid   = 1'b0;
        b_resp    = 2'b00;
        bresp_cfg = 2'b00;
        b_hold    = 1'b0;
        set_vec(3, 64'h0000_0000_8000_1004, 32'hDEAD_BEEF);
        set_vec(2, 64'h0000_0000_9000_0003, 32'h1234_5678);
        set_vec(5, 64'h0000_0000_A000_0008, 32'hCAFE_F00D);
        set_vec(4, 64'h0000_0000_B000_0010, 32'h0BAD_CAFE);
        set_vec(7, 64'h0000_0000_C000_0104, 32'h7777_0007);
        intr_vec  = {4'd2, 4'd4, 4'd5, 4'd3};   // pip->2, pmip->4, fip->5, cip->3
        tick(3);

        // reset state
        check("rst_aw_valid", 64'(aw_valid), 64'd0);
        check("rst_w_valid",  64'(w_valid),  64'd0);
        check("rst_b_ready",  64'(b_ready),  64'd0);
        check("rst_ar_valid", 64'(ar_valid), 64'd0);
        check("rst_r_ready",  64'(r_ready),  64'd1);
        check("rst_err",      64'(msi_err),  64'd0);
        check("rst_err_vec",  64'(msi_err_vec), 64'd0);
        check("rst_err_cnt",  64'(err_cnt),  64'd0);
        check("rst_err_addr", err_addr,      64'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: cip edge -> vector 3, upper lane
        c0 = cyc;
        intr_pend[0] = 1'b1;
        wait_b(1, "t1_b_done");
        check("t1_latency",  64'(aw_cyc - c0), 64'd3);
        check("t1_awaddr",   addr_log[0],  64'h0000_0000_8000_1004);
        check("t1_awsize",   64'(size_log[0]), 64'd2);
        check("t1_wdata",    wdata_log[0], 64'hDEAD_BEEF_DEAD_BEEF);
        check("t1_wstrb",    64'(wstrb_log[0]), 64'hF0);
        check("t1_fields",   64'(field_bad), 64'd0);
        tick(10);
        check("t1_no_dup",   64'(aw_cnt), 64'd1);

        // 2: masked vector is held, then sent exactly once after unmask
        intr_pend[0] = 1'b0;
        tick(2);
        msi_mask[3]  = 1'b1;
        intr_pend[0] = 1'b1;
        tick(100);
        check("t2_masked_hold", 64'(aw_cnt), 64'd1);
        msi_mask[3] = 1'b0;
        wait_b(2, "t2_b_done");
        tick(10);
        check("t2_once",   64'(aw_cnt), 64'd2);
        check("t2_awaddr", addr_log[1], 64'h0000_0000_8000_1004);

        // 3: fip->5 and pip->2 together -> 2 first, addr bits [1:0] dropped, low lane
        intr_pend[1] = 1'b1;
        intr_pend[3] = 1'b1;
        wait_b(4, "t3_b_done");
        check("t3_first_addr",  addr_log[2], 64'h0000_0000_9000_0000);
        check("t3_first_strb",  64'(wstrb_log[2]), 64'h0F);
        check("t3_first_data",  wdata_log[2], 64'h1234_5678_1234_5678);
        check("t3_second_addr", addr_log[3], 64'h0000_0000_A000_0008);
        check("t3_second_data", wdata_log[3], 64'hCAFE_F00D_CAFE_F00D);

        // 4: AW stalled, W accepted first, AW held stable
        aw_ready     = 1'b0;
        intr_pend[2] = 1'b1;
        tick(12);
        check("t4_aw_stalled", 64'(aw_cnt), 64'd4);
        check("t4_w_accepted", 64'(w_cnt),  64'd5);
        aw_ready = 1'b1;
        wait_b(5, "t4_b_done");
        check("t4_w_before_aw", 64'(w_cyc < aw_cyc), 64'd1);
        check("t4_aw_stable",   64'(stable_viol), 64'd0);
        check("t4_awaddr",      addr_log[4], 64'h0000_0000_B000_0010);
        check("t4_one_msi",     64'(aw_cnt), 64'd5);

        // 5: SLVERR on vector 7
        intr_pend[2] = 1'b0;
        tick(2);
        intr_vec[11:8] = 4'd7;
        bresp_cfg      = 2'b10;
        intr_pend[2]   = 1'b1;
        wait_b(6, "t5_b_done");
        tick(3);
        bresp_cfg = 2'b00;
        check("t5_err_pulse", 64'(err_pulses),   64'd1);
        check("t5_err_vec",   64'(err_vec_seen), 64'd7);
        check("t5_awaddr",    addr_log[5],       64'h0000_0000_C000_0104);
        check("t5_wstrb",     64'(wstrb_log[5]), 64'hF0);
`ifdef IOMMU_MSI_ERR_LOG_EN
        check("t5_err_cnt",  64'(err_cnt), 64'd1);
        check("t5_err_addr", err_addr,     64'h0000_0000_C000_0104);
`else
        check("t5_err_cnt",  64'(err_cnt), 64'd0);
        check("t5_err_addr", err_addr,     64'd0);
`endif

        // 6a: edge while disabled is dropped
        intr_pend[0] = 1'b0;
        tick(2);
        msi_en       = 1'b0;
        intr_pend[0] = 1'b1;
        tick(20);
        msi_en = 1'b1;
        tick(20);
        check("t6_disabled_drop", 64'(aw_cnt), 64'd6);

        // 6b: reset while waiting for B
        intr_pend[0] = 1'b0;
        tick(2);
        b_hold       = 1'b1;
        intr_pend[0] = 1'b1;
        k = 0;
        while (!b_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t6_in_wait_b", 64'(b_ready), 64'd1);
        rst_n     = 1'b0;
        intr_pend = '0;
        tick(1);
        check("t6_rst_aw_valid", 64'(aw_valid), 64'd0);
        check("t6_rst_w_valid",  64'(w_valid),  64'd0);
        check("t6_rst_b_ready",  64'(b_ready),  64'd0);
        b_cnt  = aw_cnt;
        b_hold = 1'b0;
        rst_n  = 1'b1;
        tick(20);
        check("t6_pend_cleared", 64'(aw_cnt), 64'd7);
        intr_pend[0] = 1'b1;
        wait_b(8, "t6_recover_b");
        check("t6_recover_addr", addr_log[7], 64'h0000_0000_8000_1004);
        check("all_fields",      64'(field_bad), 64'd0);
        check("read_chan_idle",  64'(rd_bad),    64'd0);
        check("no_extra_err",    64'(err_pulses), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
